// File: rtl/framebuffer_arbiter_pkg.sv
// framebuffer_arbiter_pkg
// Shared constants, arbiter state encoding and the line-base helper used by
// the framebuffer arbiter and its display address generator.
// No ports; imported with framebuffer_arbiter_pkg::*.
package framebuffer_arbiter_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int BPP            = 4;
  localparam int PIX_PER_WORD   = 16 / BPP;
  localparam int ADDR_W         = 17;
  localparam int WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;

  // One past the last framebuffer word; display addresses at or above this wrap to 0.
  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(WORDS_PER_LINE * V_ACTIVE);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_FETCH0 = 2'd1,
    ST_RUN    = 2'd2
  } arbState_e;

  // Word address of the first word of a line: row*160 built from two shifts
  // so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] lineBase(input logic [8:0] row);
    logic [ADDR_W-1:0] r;
    r = {{(ADDR_W-9){1'b0}}, row};
    return (r << 7) + (r << 5);
  endfunction

endpackage

// File: rtl/framebuffer_arbiter_disp_addr_gen.sv
// fb_disp_addr_gen
// Tracks the two-clock pixel phase and computes the address of the next
// display word to prefetch from the current row/column.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   row, column   visible position from the VGA controller
//   phase         0 on the first clk of a pixel, 1 on the second
//   fetchAddr     address of the word after the current 4-pixel group,
//                 wrapping to the next line and to 0 after the last line
module fb_disp_addr_gen
  import framebuffer_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        row,
  input  logic [9:0]        column,
  output logic              phase,
  output logic [ADDR_W-1:0] fetchAddr
);

  logic [9:0]        prevColumn;
  logic              phaseReg;
  logic              colChanged;
  logic [ADDR_W-1:0] sum;

  // A column change always marks the first clk of a pixel; otherwise the
  // phase simply alternates, so a held column still splits into 2-clk pixels.
  always_comb begin
    colChanged = (column != prevColumn);
    phase      = colChanged ? 1'b0 : phaseReg;
  end

  // Remember the last column and the phase to use if the column stays put.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prevColumn <= '0;
      phaseReg   <= 1'b0;
    end else begin
      prevColumn <= column;
      phaseReg   <= ~phase;
    end
  end

  // Next word = line base + group + 1. The last group of a line naturally
  // lands on word 0 of the next line; only the end of the frame needs a wrap.
  always_comb begin
    sum       = lineBase(row) + {{(ADDR_W-8){1'b0}}, column[9:2]} + ADDR_W'(1);
    fetchAddr = (sum >= FB_WORDS) ? '0 : sum;
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
// Shares one single-port synchronous SRAM between display refresh (always
// wins) and a draw engine, and unpacks 4 bpp pixels for the DAC.
// Ports:
//   clk, rst                 50 MHz clock, synchronous active-low reset
//   displayActive, row,      VGA controller timing; column advances every
//   column                   2 clk
//   pixel                    registered colour index, 1 clk after column
//   drawReq/We/Addr/WrData   draw request, held until drawGnt
//   drawGnt                  transaction is on the SRAM pins this cycle
//   drawRdData, drawRdValid  read return, 1 clk after a read grant; data
//                            holds until the next draw read
//   memEn/We/Addr/WrData     SRAM command pins
//   memRdData                SRAM read data, 1 clk after a read
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              displayActive,
  input  logic [8:0]        row,
  input  logic [9:0]        column,
  output logic [BPP-1:0]    pixel,
  input  logic              drawReq,
  input  logic              drawWe,
  input  logic [ADDR_W-1:0] drawAddr,
  input  logic [15:0]       drawWrData,
  output logic              drawGnt,
  output logic [15:0]       drawRdData,
  output logic              drawRdValid,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [15:0]       memWrData,
  input  logic [15:0]       memRdData
);

  arbState_e         state;
  logic              phase;
  logic [ADDR_W-1:0] fetchAddr;
  logic              dispSlot;
  logic [15:0]       curWord;
  logic [15:0]       nextWord;
  logic [15:0]       drawRdHold;
  logic              rdPending;
  logic              rdTag;

  fb_disp_addr_gen addrGen (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .column    (column),
    .phase     (phase),
    .fetchAddr (fetchAddr)
  );

  // SRAM ownership for this cycle. The display takes the first clk of every
  // 4-pixel group (1 in 8 clk), so a draw request waits at most one cycle.
  // Nothing is issued outside RUN except the frame-start prefetch of word 0.
  always_comb begin
    dispSlot  = (state == ST_RUN) && displayActive && (column[1:0] == 2'd0) && !phase;
    drawGnt   = (state == ST_RUN) && !dispSlot && drawReq;
    memEn     = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    if (state == ST_FETCH0) begin
      memEn = 1'b1;
    end else if (dispSlot) begin
      memEn   = 1'b1;
      memAddr = fetchAddr;
    end else if (drawGnt) begin
      memEn     = 1'b1;
      memWe     = drawWe;
      memAddr   = drawAddr;
      memWrData = drawWe ? drawWrData : '0;
    end
  end

  // Start-up sequencing plus the read tag: rdPending marks that memRdData is
  // valid next cycle and rdTag says whether it belongs to the draw engine.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_INIT;
      rdPending <= 1'b0;
      rdTag     <= 1'b0;
    end else begin
      case (state)
        ST_INIT:   state <= ST_FETCH0;
        ST_FETCH0: state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
      rdPending <= memEn && !memWe;
      rdTag     <= drawGnt;
    end
  end

  // Draw read data passes straight through on its valid cycle and is then
  // held so the engine can pick it up later.
  always_comb begin
    drawRdValid = rdPending && rdTag;
    drawRdData  = drawRdValid ? memRdData : drawRdHold;
  end

  // Word buffers and pixel mux. curWord swaps on the last clk of a group so
  // the final pixel still reads the old word; the swap is not gated by
  // displayActive, which lets the word prefetched at end of line (or at frame
  // start) become current during blanking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      curWord    <= '0;
      nextWord   <= '0;
      drawRdHold <= '0;
      pixel      <= '0;
    end else begin
      if (rdPending && !rdTag) begin
        nextWord <= memRdData;
      end
      if (drawRdValid) begin
        drawRdHold <= memRdData;
      end
      if ((column[1:0] == 2'd3) && phase) begin
        curWord <= nextWord;
      end
      pixel <= displayActive ? curWord[{column[1:0], 2'b00} +: BPP] : '0;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter
// Directed bench for framebuffer_arbiter with a behavioural synchronous SRAM.
// Inputs change 1 time unit after the rising edge, outputs are sampled 3
// units after it.
module tb_framebuffer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        displayActive;
  logic [8:0]  row;
  logic [9:0]  column;
  logic [3:0]  pixel;
  logic        drawReq;
  logic        drawWe;
  logic [16:0] drawAddr;
  logic [15:0] drawWrData;
  logic        drawGnt;
  logic [15:0] drawRdData;
  logic        drawRdValid;
  logic        memEn;
  logic        memWe;
  logic [16:0] memAddr;
  logic [15:0] memWrData;
  logic [15:0] memRdData;

  logic [15:0] sram [0:131071];

  int checks   = 0;
  int failures = 0;

  framebuffer_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .displayActive (displayActive),
    .row           (row),
    .column        (column),
    .pixel         (pixel),
    .drawReq       (drawReq),
    .drawWe        (drawWe),
    .drawAddr      (drawAddr),
    .drawWrData    (drawWrData),
    .drawGnt       (drawGnt),
    .drawRdData    (drawRdData),
    .drawRdValid   (drawRdValid),
    .memEn         (memEn),
    .memWe         (memWe),
    .memAddr       (memAddr),
    .memWrData     (memWrData),
    .memRdData     (memRdData)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM: read data appears the cycle after the read.
  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) begin
        sram[memAddr] <= memWrData;
      end else begin
        memRdData <= sram[memAddr];
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input logic da, input logic [8:0] r, input logic [9:0] c);
    displayActive = da;
    row           = r;
    column        = c;
  endtask

  task automatic applyDraw(input logic req, input logic we, input logic [16:0] addr,
                           input logic [15:0] data);
    drawReq    = req;
    drawWe     = we;
    drawAddr   = addr;
    drawWrData = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic holdColumn(input logic da, input logic [8:0] r, input logic [9:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(da, r, c);
      nextCycle();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " pixel"},       32'(pixel),       32'd0);
    checkOutput({tag, " drawGnt"},     32'(drawGnt),     32'd0);
    checkOutput({tag, " drawRdValid"}, 32'(drawRdValid), 32'd0);
    checkOutput({tag, " drawRdData"},  32'(drawRdData),  32'd0);
    checkOutput({tag, " memEn"},       32'(memEn),       32'd0);
    checkOutput({tag, " memWe"},       32'(memWe),       32'd0);
    checkOutput({tag, " memAddr"},     32'(memAddr),     32'd0);
    checkOutput({tag, " memWrData"},   32'(memWrData),   32'd0);
  endtask

  // Walks columns 0..7 of a visible line; expected pixels are the nibbles of
  // the two words the bench placed in the SRAM for that line.
  task automatic showPixels(input logic [8:0] r, input logic [16:0] firstAddr,
                            input logic [15:0] w0, input logic [15:0] w1);
    logic [31:0] pair;
    logic [3:0]  expPix;
    pair = {w1, w0};
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, r, 10'(c));
      if (c == 0) begin
        settle();
        checkOutput($sformatf("row%0d first fetch memEn", r), 32'(memEn), 32'd1);
        checkOutput($sformatf("row%0d first fetch memAddr", r), 32'(memAddr), 32'(firstAddr));
      end
      nextCycle();
      settle();
      expPix = pair[4*c +: 4];
      checkOutput($sformatf("row%0d col%0d pixel", r, c), 32'(pixel), 32'(expPix));
      nextCycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) begin
      sram[i] = 16'h0000;
    end
    sram[0]   = 16'h3210;
    sram[1]   = 16'h7654;
    sram[161] = 16'hA1B2;
    sram[320] = 16'h89AB;
    sram[321] = 16'hCDEF;
    memRdData = 16'h0000;

    // Reset held for three edges, everything quiet.
    rst = 1'b0;
    applyStimulus(1'b0, 9'd0, 10'd639);
    applyDraw(1'b0, 1'b0, 17'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      settle();
      checkAllZero($sformatf("reset clk%0d", i));
    end
    rst = 1'b1;

    // Frame-start prefetch of word 0.
    nextCycle();
    settle();
    checkOutput("fetch0 memEn",   32'(memEn),   32'd1);
    checkOutput("fetch0 memWe",   32'(memWe),   32'd0);
    checkOutput("fetch0 memAddr", 32'(memAddr), 32'd0);
    checkOutput("fetch0 drawGnt", 32'(drawGnt), 32'd0);
    nextCycle();

    // Blanking columns let the prefetched word become current, then row 0.
    holdColumn(1'b0, 9'd0, 10'd638, 2);
    holdColumn(1'b0, 9'd0, 10'd639, 2);
    showPixels(9'd0, 17'd1, 16'h3210, 16'h7654);

    // End-of-line and end-of-frame address wrap.
    applyStimulus(1'b1, 9'd0, 10'd636);
    settle();
    checkOutput("wrap row0 memEn",   32'(memEn),   32'd1);
    checkOutput("wrap row0 memAddr", 32'(memAddr), 32'd160);
    nextCycle();
    settle();
    checkOutput("second clk no fetch memEn", 32'(memEn), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 9'd0, 10'd637);
    nextCycle();
    applyStimulus(1'b1, 9'd479, 10'd636);
    settle();
    checkOutput("wrap frame memEn",   32'(memEn),   32'd1);
    checkOutput("wrap frame memAddr", 32'(memAddr), 32'd0);
    nextCycle();

    // Draw write colliding with a display slot is deferred one clk.
    applyStimulus(1'b1, 9'd0, 10'd4);
    applyDraw(1'b1, 1'b1, 17'd5, 16'hBEEF);
    settle();
    checkOutput("collide drawGnt", 32'(drawGnt), 32'd0);
    checkOutput("collide memAddr", 32'(memAddr), 32'd2);
    checkOutput("collide memWe",   32'(memWe),   32'd0);
    nextCycle();
    settle();
    checkOutput("deferred drawGnt",   32'(drawGnt),   32'd1);
    checkOutput("deferred memWe",     32'(memWe),     32'd1);
    checkOutput("deferred memAddr",   32'(memAddr),   32'd5);
    checkOutput("deferred memWrData", 32'(memWrData), 32'hBEEF);
    nextCycle();
    applyDraw(1'b0, 1'b0, 17'd0, 16'h0000);
    applyStimulus(1'b1, 9'd0, 10'd5);
    settle();
    checkOutput("idle drawGnt", 32'(drawGnt), 32'd0);
    checkOutput("idle memEn",   32'(memEn),   32'd0);
    nextCycle();

    // Draw read with no display slot: same-clk grant, data next clk.
    applyDraw(1'b1, 1'b0, 17'd161, 16'h0000);
    settle();
    checkOutput("read161 drawGnt", 32'(drawGnt), 32'd1);
    checkOutput("read161 memAddr", 32'(memAddr), 32'd161);
    checkOutput("read161 memWe",   32'(memWe),   32'd0);
    nextCycle();
    applyDraw(1'b0, 1'b0, 17'd0, 16'h0000);
    settle();
    checkOutput("read161 drawRdValid", 32'(drawRdValid), 32'd1);
    checkOutput("read161 drawRdData",  32'(drawRdData),  32'hA1B2);
    nextCycle();
    applyDraw(1'b1, 1'b0, 17'd5, 16'h0000);
    settle();
    checkOutput("hold drawRdValid", 32'(drawRdValid), 32'd0);
    checkOutput("hold drawRdData",  32'(drawRdData),  32'hA1B2);
    checkOutput("read5 drawGnt",    32'(drawGnt),     32'd1);
    nextCycle();
    applyDraw(1'b0, 1'b0, 17'd0, 16'h0000);
    settle();
    checkOutput("read5 drawRdValid", 32'(drawRdValid), 32'd1);
    checkOutput("read5 drawRdData",  32'(drawRdData),  32'hBEEF);
    nextCycle();

    // Out-of-range draw address goes out unmodified.
    applyDraw(1'b1, 1'b1, 17'd100000, 16'h1234);
    settle();
    checkOutput("oob drawGnt", 32'(drawGnt), 32'd1);
    checkOutput("oob memAddr", 32'(memAddr), 32'd100000);
    checkOutput("oob memWe",   32'(memWe),   32'd1);
    nextCycle();

    // Mid-line reset, restart, then a correct next line.
    applyDraw(1'b0, 1'b0, 17'd0, 16'h0000);
    rst = 1'b0;
    applyStimulus(1'b1, 9'd1, 10'd300);
    nextCycle();
    settle();
    checkAllZero("midline reset");
    rst = 1'b1;
    nextCycle();
    settle();
    checkOutput("restart fetch0 memEn",   32'(memEn),   32'd1);
    checkOutput("restart fetch0 memAddr", 32'(memAddr), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 9'd1, 10'd636);
    settle();
    checkOutput("row1 end fetch memAddr", 32'(memAddr), 32'd320);
    nextCycle();
    holdColumn(1'b1, 9'd1, 10'd637, 2);
    holdColumn(1'b1, 9'd1, 10'd638, 2);
    holdColumn(1'b1, 9'd1, 10'd639, 2);
    holdColumn(1'b0, 9'd1, 10'd639, 2);
    settle();
    checkOutput("blanking pixel", 32'(pixel), 32'd0);
    showPixels(9'd2, 17'd321, 16'h89AB, 16'hCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
